// File: rtl/gbt_link_xu5.sv
// gbt_link_xu5 - frame-level GBT-style optical link core for the XU5 SFP1 lane.
// TX serialises 84-bit user words into 120-bit frames, one line bit per clock.
// RX shifts in the lane, finds the frame boundary by bitslipping and reports lock.
// Optional feature macro: GBT_CRC_CHECK_EN (CRC-32 check field instead of zeros).
module gbt_link_xu5 #(
    parameter int DEBUG = 0
) (
    input  logic        external_pll_source_120mhz,
    input  logic        reset_n,
    input  logic        i_sfp1_los,
    input  logic        i_sfp1_gbitin_p,
    input  logic        i_sfp1_gbitin_n,
    output logic        o_sfp1_gbitout_p,
    output logic        o_sfp1_gbitout_n,
    input  logic [83:0] i_data_sent,
    input  logic        i_bitslip_reset,
    output logic [83:0] o_data_received,
    output logic        o_link_ready
);

    localparam logic [3:0] HDR_DATA = 4'b0101;
    localparam logic [3:0] HDR_IDLE = 4'b0110;
    localparam logic [6:0] CNT_LAST = 7'd119;

    typedef enum logic [1:0] {
        ST_LOS,
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    // Debug probes may be attached here; the block has no functional content.
    if (DEBUG != 0) begin : g_debug_probe
    end

`ifdef GBT_CRC_CHECK_EN
    // CRC-32, poly 0x04C11DB7, init all ones, MSB first, no reflection, no final XOR.
    function automatic logic [31:0] crc32_88(input logic [87:0] d);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 87; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ 32'h04C1_1DB7;
            end
        end
        return c;
    endfunction
`endif

    logic [6:0]   r_tx_cnt;
    logic [119:0] r_tx_shift;
    logic         r_tx_bit;
    logic [31:0]  w_tx_check;
    logic [119:0] w_tx_frame;

    logic [119:0] r_rx_shift;
    logic [6:0]   r_rx_cnt;
    logic         r_slip_pending;
    logic [119:0] w_frame;
    logic         w_eval;
    logic         w_hdr_ok;
    logic         w_is_data;
    logic         w_crc_ok;
    logic         w_good;

    state_t       r_state;
    logic [6:0]   r_slip_cnt;
    logic [3:0]   r_good_cnt;
    logic [2:0]   r_bad_cnt;
    logic [83:0]  r_data_received;
    logic         r_link_ready;
    logic         w_unused;

    // The frame about to be evaluated includes the bit arriving at this edge.
    assign w_frame   = {r_rx_shift[118:0], i_sfp1_gbitin_p};
    assign w_eval    = (r_rx_cnt == CNT_LAST);
    assign w_hdr_ok  = (w_frame[119:116] == HDR_DATA) || (w_frame[119:116] == HDR_IDLE);
    assign w_is_data = (w_frame[119:116] == HDR_DATA);

`ifdef GBT_CRC_CHECK_EN
    assign w_tx_check = crc32_88({HDR_DATA, i_data_sent});
    assign w_crc_ok   = (crc32_88(w_frame[119:32]) == w_frame[31:0]);
`else
    assign w_tx_check = 32'h0;
    assign w_crc_ok   = 1'b1;
`endif

    assign w_good     = w_hdr_ok && w_crc_ok;
    assign w_tx_frame = {HDR_DATA, i_data_sent, w_tx_check};

    assign o_sfp1_gbitout_p = r_tx_bit;
    assign o_sfp1_gbitout_n = ~r_tx_bit;
    assign o_data_received  = r_data_received;
    assign o_link_ready     = r_link_ready;

    // Only the positive leg of the RX pair is sampled.
    assign w_unused = ^{i_sfp1_gbitin_n, r_rx_shift[119], w_frame[31:0], r_slip_cnt};

    // TX: free-running bit counter; latch the user word at count 0 and shift MSB first.
    always_ff @(posedge external_pll_source_120mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_cnt   <= 7'd0;
            r_tx_shift <= '0;
            r_tx_bit   <= 1'b0;
        end else begin
            r_tx_cnt <= (r_tx_cnt == CNT_LAST) ? 7'd0 : r_tx_cnt + 7'd1;
            if (r_tx_cnt == 7'd0) begin
                r_tx_bit   <= w_tx_frame[119];
                r_tx_shift <= {w_tx_frame[118:0], 1'b0};
            end else begin
                r_tx_bit   <= r_tx_shift[119];
                r_tx_shift <= {r_tx_shift[118:0], 1'b0};
            end
        end
    end

    // RX: shift every clock; a pending bitslip holds the frame counter for one clock.
    always_ff @(posedge external_pll_source_120mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_shift <= '0;
            r_rx_cnt   <= 7'd0;
        end else begin
            r_rx_shift <= w_frame;
            if (!r_slip_pending) begin
                r_rx_cnt <= (r_rx_cnt == CNT_LAST) ? 7'd0 : r_rx_cnt + 7'd1;
            end
        end
    end

    // RX alignment FSM: LOS beats bitslip_reset, which beats frame evaluation.
    always_ff @(posedge external_pll_source_120mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_LOS;
            r_slip_cnt      <= 7'd0;
            r_good_cnt      <= 4'd0;
            r_bad_cnt       <= 3'd0;
            r_slip_pending  <= 1'b0;
            r_data_received <= '0;
            r_link_ready    <= 1'b0;
        end else begin
            r_slip_pending <= 1'b0;
            if (i_sfp1_los) begin
                r_state      <= ST_LOS;
                r_link_ready <= 1'b0;
                r_good_cnt   <= 4'd0;
                r_bad_cnt    <= 3'd0;
            end else if (r_state == ST_LOS) begin
                r_state <= ST_HUNT;
            end else if (i_bitslip_reset) begin
                r_state      <= ST_HUNT;
                r_link_ready <= 1'b0;
                r_slip_cnt   <= 7'd0;
                r_good_cnt   <= 4'd0;
                r_bad_cnt    <= 3'd0;
            end else if (w_eval) begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_good) begin
                            r_state    <= ST_VERIFY;
                            r_good_cnt <= 4'd1;
                        end else begin
                            r_slip_pending <= 1'b1;
                            r_slip_cnt     <= (r_slip_cnt == CNT_LAST) ? 7'd0 : r_slip_cnt + 7'd1;
                        end
                    end
                    ST_VERIFY: begin
                        if (w_good) begin
                            r_good_cnt <= r_good_cnt + 4'd1;
                            if (r_good_cnt == 4'd7) begin
                                r_state      <= ST_LOCKED;
                                r_link_ready <= 1'b1;
                                r_bad_cnt    <= 3'd0;
                            end
                        end else begin
                            r_state        <= ST_HUNT;
                            r_good_cnt     <= 4'd0;
                            r_slip_pending <= 1'b1;
                            r_slip_cnt     <= (r_slip_cnt == CNT_LAST) ? 7'd0 : r_slip_cnt + 7'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_good) begin
                            r_bad_cnt <= 3'd0;
                            if (w_is_data) begin
                                r_data_received <= w_frame[115:32];
                            end
                        end else if (r_bad_cnt == 3'd3) begin
                            r_state      <= ST_HUNT;
                            r_link_ready <= 1'b0;
                            r_bad_cnt    <= 3'd0;
                            r_good_cnt   <= 4'd0;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + 3'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_LOS;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gbt_link_xu5.sv
// tb_gbt_link_xu5 - loopback bench for gbt_link_xu5 with directed header corruption.
`timescale 1ns/1ps
module tb_gbt_link_xu5;

    localparam logic [83:0] DATA_C = 84'hc000babeac1dacdcfffff;
    localparam logic [83:0] DATA_A = 84'h123456789abcdef012345;
    localparam logic [83:0] DATA_B = 84'hfedcba9876543210fedcb;
    localparam logic [83:0] DATA_D = 84'h0a5a5a5a5a5a5a5a5a5a5;
    localparam int LOCK_BUDGET = 130 * 120;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        los = 1'b1;
    logic        bitslipReset = 1'b0;
    logic [83:0] dataSent = DATA_C;
    logic [83:0] dataReceived;
    logic        linkReady;
    logic        gbitoutP;
    logic        gbitoutN;
    logic        gbitinP;
    logic        gbitinN;
    logic        kill = 1'b0;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          cyc = 0;
    int          corruptLeft = 0;
    int          lineErrs = 0;
    logic [83:0] curData = DATA_C;

    always #4 clk = ~clk;

    // Loopback with an optional forced-zero window over the TX header bits.
    assign gbitinP = gbitoutP & ~kill;
    assign gbitinN = ~gbitinP;

    gbt_link_xu5 dut (
        .external_pll_source_120mhz(clk),
        .reset_n(rstN),
        .i_sfp1_los(los),
        .i_sfp1_gbitin_p(gbitinP),
        .i_sfp1_gbitin_n(gbitinN),
        .o_sfp1_gbitout_p(gbitoutP),
        .o_sfp1_gbitout_n(gbitoutN),
        .i_data_sent(dataSent),
        .i_bitslip_reset(bitslipReset),
        .o_data_received(dataReceived),
        .o_link_ready(linkReady)
    );

    // Track the TX bit phase (edge index since reset release) and zero header bits on request.
    always @(posedge clk) begin
        if (rstN) begin
            if (corruptLeft > 0 && (cyc % 120) < 4) begin
                kill <= 1'b1;
                if ((cyc % 120) == 3) corruptLeft = corruptLeft - 1;
            end else begin
                kill <= 1'b0;
            end
            cyc = cyc + 1;
        end
    end

    // The TX pair must always be complementary.
    always @(negedge clk) begin
        if (gbitoutN !== ~gbitoutP) lineErrs = lineErrs + 1;
    end

    // Advance to the negedge following the next edge at which the TX counter equals k.
    task automatic waitTc(input int k);
        @(negedge clk);
        for (int i = 0; i < 130 && ((cyc - 1) % 120) != k; i++) @(negedge clk);
    endtask

    task automatic waitLock(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LOCK_BUDGET && !ok; i++) begin
            @(negedge clk);
            if (linkReady === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        testsRun++;
        if (linkReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_link: got %b, expected 0", linkReady); end
        testsRun++;
        if (dataReceived !== 84'h0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h, expected 0", dataReceived); end
        testsRun++;
        if (gbitoutP !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_p: got %b, expected 0", gbitoutP); end
        testsRun++;
        if (gbitoutN !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_out_n: got %b, expected 1", gbitoutN); end
        rstN = 1'b1;
        repeat (360) @(negedge clk);
        testsRun++;
        if (linkReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL los_no_link: got %b, expected 0", linkReady); end
    endtask

    task automatic test_lock;
        bit ok;
        los = 1'b0;
        waitLock(ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL lock_time: link_ready %b, expected 1 within budget", linkReady); end
        repeat (240) @(negedge clk);
        testsRun++;
        if (dataReceived !== DATA_C) begin testsFailed++; $display("[TB] FAIL lock_data: got %h, expected %h", dataReceived, DATA_C); end
    endtask

    task automatic test_data_latency;
        waitTc(119);
        dataSent = DATA_A;
        @(negedge clk);
        dataSent = DATA_B;
        repeat (119) @(negedge clk);
        testsRun++;
        if (dataReceived !== DATA_C) begin testsFailed++; $display("[TB] FAIL latency_early: got %h, expected %h", dataReceived, DATA_C); end
        @(negedge clk);
        testsRun++;
        if (dataReceived !== DATA_A) begin testsFailed++; $display("[TB] FAIL latency_first: got %h, expected %h", dataReceived, DATA_A); end
        waitTc(0);
        testsRun++;
        if (dataReceived !== DATA_B) begin testsFailed++; $display("[TB] FAIL midframe_change: got %h, expected %h", dataReceived, DATA_B); end
        curData = DATA_B;
    endtask

    task automatic test_los;
        bit ok;
        logic [83:0] held;
        waitTc(50);
        held = dataReceived;
        los = 1'b1;
        @(negedge clk);
        testsRun++;
        if (linkReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL los_drop: got %b, expected 0", linkReady); end
        repeat (119) @(negedge clk);
        testsRun++;
        if (dataReceived !== held) begin testsFailed++; $display("[TB] FAIL los_hold: got %h, expected %h", dataReceived, held); end
        los = 1'b0;
        waitLock(ok);
        repeat (240) @(negedge clk);
        testsRun++;
        if (ok !== 1'b1 || dataReceived !== curData) begin
            testsFailed++; $display("[TB] FAIL los_relock: lock %b data %h, expected lock 1 data %h", ok, dataReceived, curData);
        end
    endtask

    task automatic test_single_bad;
        waitTc(119);
        dataSent = DATA_D;
        corruptLeft = 1;
        @(negedge clk);
        dataSent = curData;
        repeat (120) @(negedge clk);
        testsRun++;
        if (linkReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_bad_link: got %b, expected 1", linkReady); end
        testsRun++;
        if (dataReceived !== curData) begin testsFailed++; $display("[TB] FAIL single_bad_data: got %h, expected %h", dataReceived, curData); end
    endtask

    task automatic test_four_bad;
        bit ok;
        waitTc(119);
        corruptLeft = 4;
        repeat (480) @(negedge clk);
        testsRun++;
        if (linkReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL three_bad_link: got %b, expected 1", linkReady); end
        @(negedge clk);
        testsRun++;
        if (linkReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL four_bad_drop: got %b, expected 0", linkReady); end
        waitLock(ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL four_bad_relock: got %b, expected 1", linkReady); end
    endtask

    task automatic test_bitslip_reset;
        bit ok;
        waitTc(30);
        bitslipReset = 1'b1;
        @(negedge clk);
        bitslipReset = 1'b0;
        testsRun++;
        if (linkReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL bitslip_drop: got %b, expected 0", linkReady); end
        waitLock(ok);
        repeat (240) @(negedge clk);
        testsRun++;
        if (ok !== 1'b1 || dataReceived !== curData) begin
            testsFailed++; $display("[TB] FAIL bitslip_relock: lock %b data %h, expected lock 1 data %h", ok, dataReceived, curData);
        end
    endtask

    task automatic test_line_polarity;
        testsRun++;
        if (lineErrs !== 0) begin testsFailed++; $display("[TB] FAIL tx_pair: got %0d bad clocks, expected 0", lineErrs); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_data_latency();
        test_los();
        test_single_bad();
        test_four_bad();
        test_bitslip_reset();
        test_line_polarity();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
